matrix_transpose_ctrl: RTL and testbench
========================================

# matrix_transpose_ctrl

Streaming controller around the combinational `matrix_transpose` datapath. It accepts one square matrix element-by-element in row-major order over a valid/ready interface and stores it in a local buffer. It then streams the transposed matrix out row-major, which is the original matrix in column-major order, over a second valid/ready interface. It sits between the EEG covariance/feature producers and downstream matrix-multiply stages that need the transposed operand.

## Interface
- `MATRIX_SIZE`, 3: matrix dimension N (N×N), N ≥ 2.
- `WORD_LENGTH`, 8: element width in bits.
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  WORD_LENGTH  input element.
- `in_valid`  in  1  `in_data` is valid.
- `in_last`  in  1  producer marks the final element of a matrix; used for checking only.
- `in_ready`  out  1  block accepts an element this cycle.
- `out_data`  out  WORD_LENGTH  transposed element.
- `out_valid`  out  1  `out_data` is valid.
- `out_last`  out  1  final element of the transposed matrix.
- `out_ready`  in  1  consumer accepts an element this cycle.
- `busy`  out  1  high while the block is in DRAIN.
- `frame_err`  out  1  one-cycle pulse when `in_last` disagrees with the element count.

## Operation
- Two states: LOAD and DRAIN. Reset state is LOAD.
- LOAD:
  - `in_ready`=1 and `out_valid`=0.
  - When `in_valid && in_ready` (an input handshake): write `buf[in_row][in_col]` and advance `in_col`. `in_col` wraps at N-1 to 0 and increments `in_row`.
  - On the handshake at `in_row`=`in_col`=N-1: go to DRAIN and clear both input counters.
- DRAIN:
  - `in_ready`=0 and `out_valid`=1.
  - `out_data` = `A_t[out_row][out_col]` from the `matrix_transpose` instance fed by `buf`, which equals `buf[out_col][out_row]`.
  - `out_last` = (`out_row`=`out_col`=N-1) && `out_valid`.
  - When `out_valid && out_ready`: advance `out_col`/`out_row` with the same wrap rule as the input counters.
  - On the handshake with `out_last`=1: return to LOAD and clear both output counters.
- Framing: the element count alone decides the matrix boundary; `in_last` never alters control flow.
  - `frame_err` pulses the cycle after an input handshake whose `in_last` ≠ (element is the N²-th).
- `out_data` is valid only while `out_valid`=1. It holds stable while `out_valid && !out_ready`.
- Counter widths: `$clog2(MATRIX_SIZE)` bits, minimum 1.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_last`=0, `busy`=0, `frame_err`=0, `out_data`=0. All counters are 0. `buf` is cleared to 0.
- Reset asserted mid-LOAD or mid-DRAIN: the partial matrix is discarded. The next cycle is LOAD with all counters at 0.
- Latency: `out_valid` rises the cycle after the last input handshake. The first output equals `buf[0][0]`.
- Throughput with no stalls: N² load cycles plus N² drain cycles per matrix, i.e. 2N² cycles (18 for N=3).
- Inputs are never accepted during DRAIN, so a simultaneous input and output handshake is impossible.
- `out_ready` low holds the counters and output; there is no timeout.
- `in_valid` gaps in LOAD hold the counters; elements are never dropped.

## Configuration
- `MATRIX_TRANSPOSE_BYPASS_EN` defined:
  - Adds input port `bypass` (1 bit).
  - `bypass` is sampled on the first input handshake of each matrix (input counters at 0) and held in a flag until that matrix finishes draining.
  - Flag set: DRAIN outputs `buf[out_row][out_col]`, i.e. the original order.
  - Flag clear: DRAIN outputs the transpose as above.
  - The flag resets to 0.
- Macro undefined: no `bypass` port; the block always outputs the transpose.

## Structure
- Shared package `matrix_pkg`:
  - `typedef enum logic {LOAD, DRAIN} xpose_state_t`.
  - An index-width function/constant derived from `MATRIX_SIZE`.
- One sub-module: an instance of the existing `matrix_transpose`, driven by `buf`, with the same `MATRIX_SIZE` and `WORD_LENGTH`.
- Output element selection is a mux over the `A_t` array.

## Test plan
All scenarios use N=3, W=8.
- Basic: load 1..9 back-to-back with `in_last` on 9 and `out_ready`=1 → outputs 1,4,7,2,5,8,3,6,9; `out_last` only with 9; `frame_err` never pulses; 18 cycles total.
- Backpressure: random `out_ready` and `in_valid` gaps → same sequence; `out_data` stable across every stalled cycle; `in_ready`=0 throughout DRAIN.
- Framing: `in_last` asserted on element 5 and deasserted on element 9 → two `frame_err` pulses; output sequence unchanged.
- Reset mid-load: reset after 4 elements, then load 11..19 → outputs 11,14,17,12,15,18,13,16,19.
- Reset mid-drain: reset after 3 outputs → `out_valid`=0 next cycle and `in_ready`=1.
- Bypass (macro on): `bypass`=1 on the first element of 1..9 → outputs 1..9 in order. The next matrix loaded with `bypass`=0 → transposed order.

Source files
------------

// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared types and index-width helper for the matrix transpose blocks
// Contents:
//   xpose_state_t : controller state, LOAD (accepting elements) or DRAIN (emitting elements)
//   idx_width()   : bits needed for a row/column index of an N x N matrix, minimum 1
package matrix_pkg;

  typedef enum logic {
    LOAD  = 1'b0,
    DRAIN = 1'b1
  } xpose_state_t;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/matrix_transpose.sv
// rtl/matrix_transpose.sv - combinational N x N matrix transpose datapath
// Parameters: MATRIX_SIZE (N), WORD_LENGTH (element width)
// Ports:
//   a   in  N x N array of WORD_LENGTH elements, a[row][col]
//   a_t out N x N array, a_t[row][col] = a[col][row]
module matrix_transpose
  import matrix_pkg::*;
#(
  parameter int MATRIX_SIZE = 3,
  parameter int WORD_LENGTH = 8
) (
  input  logic [WORD_LENGTH-1:0] a   [MATRIX_SIZE][MATRIX_SIZE],
  output logic [WORD_LENGTH-1:0] a_t [MATRIX_SIZE][MATRIX_SIZE]
);

  for (genvar r = 0; r < MATRIX_SIZE; r++) begin : g_row
    for (genvar c = 0; c < MATRIX_SIZE; c++) begin : g_col
      assign a_t[r][c] = a[c][r];
    end
  end

endmodule

// File: rtl/matrix_transpose_ctrl.sv
// rtl/matrix_transpose_ctrl.sv - streaming load/drain controller around matrix_transpose
// Loads one N x N matrix row-major over in_* (valid/ready), then streams its transpose
// row-major over out_* (valid/ready).
// Parameters: MATRIX_SIZE (N >= 2), WORD_LENGTH (element width)
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_data/in_valid/in_last/in_ready   element input; in_last only feeds frame_err
//   out_data/out_valid/out_last/out_ready element output; out_last on the final element
//   busy            high while draining
//   frame_err       one-cycle pulse after an input handshake whose in_last disagrees
//                   with the element count
// Optional: MATRIX_TRANSPOSE_BYPASS_EN adds input 'bypass', sampled on the first element
//   of a matrix; when set that matrix drains in its original order.
module matrix_transpose_ctrl
  import matrix_pkg::*;
#(
  parameter int MATRIX_SIZE = 3,
  parameter int WORD_LENGTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WORD_LENGTH-1:0] in_data,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [WORD_LENGTH-1:0] out_data,
  output logic                   out_valid,
  output logic                   out_last,
  input  logic                   out_ready,
`ifdef MATRIX_TRANSPOSE_BYPASS_EN
  input  logic                   bypass,
`endif
  output logic                   busy,
  output logic                   frame_err
);

  localparam int IW = idx_width(MATRIX_SIZE);
  localparam logic [IW-1:0] LAST_IDX = IW'(MATRIX_SIZE - 1);

  xpose_state_t state, state_nxt;

  logic [IW-1:0] in_row, in_col, out_row, out_col;
  logic [WORD_LENGTH-1:0] mem_buf [MATRIX_SIZE][MATRIX_SIZE];
  logic [WORD_LENGTH-1:0] mem_t   [MATRIX_SIZE][MATRIX_SIZE];

  logic in_hs, out_hs, in_at_end, out_at_end;

  assign in_hs      = in_valid && in_ready;
  assign out_hs     = out_valid && out_ready;
  assign in_at_end  = (in_row == LAST_IDX) && (in_col == LAST_IDX);
  assign out_at_end = (out_row == LAST_IDX) && (out_col == LAST_IDX);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (in_hs && in_at_end)   state_nxt = DRAIN;
      DRAIN:   if (out_hs && out_at_end) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    in_ready  = (state == LOAD);
    out_valid = (state == DRAIN);
    busy      = (state == DRAIN);
    out_last  = (state == DRAIN) && out_at_end;
  end

  // Input position: column-fastest, cleared after the last element
  always_ff @(posedge clk) begin
    if (rst) begin
      in_row <= '0;
      in_col <= '0;
    end else if (in_hs) begin
      if (in_at_end) begin
        in_row <= '0;
        in_col <= '0;
      end else if (in_col == LAST_IDX) begin
        in_col <= '0;
        in_row <= in_row + IW'(1);
      end else begin
        in_col <= in_col + IW'(1);
      end
    end
  end

  // Output position: same wrap rule, only moves on an accepted output
  always_ff @(posedge clk) begin
    if (rst) begin
      out_row <= '0;
      out_col <= '0;
    end else if (out_hs) begin
      if (out_at_end) begin
        out_row <= '0;
        out_col <= '0;
      end else if (out_col == LAST_IDX) begin
        out_col <= '0;
        out_row <= out_row + IW'(1);
      end else begin
        out_col <= out_col + IW'(1);
      end
    end
  end

  // Element buffer; cleared on reset so out_data reads 0 out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < MATRIX_SIZE; r++)
        for (int c = 0; c < MATRIX_SIZE; c++)
          mem_buf[r][c] <= '0;
    end else if (in_hs) begin
      mem_buf[in_row][in_col] <= in_data;
    end
  end

  // in_last is advisory: a mismatch is flagged but the count still frames the matrix
  always_ff @(posedge clk) begin
    if (rst) frame_err <= 1'b0;
    else     frame_err <= in_hs && (in_last != in_at_end);
  end

  matrix_transpose #(
    .MATRIX_SIZE (MATRIX_SIZE),
    .WORD_LENGTH (WORD_LENGTH)
  ) u_transpose (
    .a   (mem_buf),
    .a_t (mem_t)
  );

`ifdef MATRIX_TRANSPOSE_BYPASS_EN
  logic bypass_flag;

  // Captured with the first element so a mid-matrix change of 'bypass' has no effect
  always_ff @(posedge clk) begin
    if (rst)
      bypass_flag <= 1'b0;
    else if (in_hs && (in_row == '0) && (in_col == '0))
      bypass_flag <= bypass;
    else if (out_hs && out_at_end)
      bypass_flag <= 1'b0;
  end

  assign out_data = bypass_flag ? mem_buf[out_row][out_col] : mem_t[out_row][out_col];
`else
  assign out_data = mem_t[out_row][out_col];
`endif

endmodule

// File: tb/tb_matrix_transpose_ctrl.sv
// tb/tb_matrix_transpose_ctrl.sv - scoreboard testbench for matrix_transpose_ctrl
module tb_matrix_transpose_ctrl;

  localparam int N = 3;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_last;
  logic         out_ready = 1'b1;
  logic         busy;
  logic         frame_err;
`ifdef MATRIX_TRANSPOSE_BYPASS_EN
  logic         bypass = 1'b0;
`endif

  matrix_transpose_ctrl #(.MATRIX_SIZE(N), .WORD_LENGTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
`ifdef MATRIX_TRANSPOSE_BYPASS_EN
    .bypass    (bypass),
`endif
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
  } exp_t;

  exp_t         q[$];
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  int           n_out = 0;
  int           ferr_seen = 0;
  int           ferr_exp = 0;
  int           last_out_cyc = 0;
  int           first_in_cyc = 0;
  bit           rand_ready = 1'b0;
  logic [W-1:0] m [N][N];
  int           idx = 0;
  bit           model_byp = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? 1'($urandom % 2) : 1'b1;
    end
  end

  // Monitor: compares every accepted output against the scoreboard
  logic [W-1:0] held;
  bit           stalled = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) check("stall_hold", out_data, held);
      if (out_valid) check("in_ready_in_drain", in_ready, 0);
      if (frame_err) ferr_seen++;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%0d required=none", out_data);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("out_data", out_data, e.d);
          check("out_last", out_last, e.l);
        end
        n_out++;
        last_out_cyc = cyc;
      end
      stalled = out_valid && !out_ready;
      held    = out_data;
    end
  end

  // Reference model: fills a matrix from the element count, and on the N*N-th
  // element queues the expected drain order (transpose unless bypassed).
  task automatic model_accept(input logic [W-1:0] v, input bit last, input bit byp);
    if (idx == 0) begin
      model_byp    = byp;
      first_in_cyc = cyc - 1;
    end
    m[idx / N][idx % N] = v;
    if (last != (idx == N * N - 1)) ferr_exp++;
    idx++;
    if (idx == N * N) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          exp_t e;
          e.d = model_byp ? m[i][j] : m[j][i];
          e.l = (i == N - 1) && (j == N - 1);
          q.push_back(e);
        end
      idx = 0;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the handshake edge
  task automatic send(input logic [W-1:0] v, input bit last, input bit byp);
    bit hs;
    in_data  = v;
    in_valid = 1'b1;
    in_last  = last;
`ifdef MATRIX_TRANSPOSE_BYPASS_EN
    bypass   = byp;
`endif
    hs = 1'b0;
    for (int k = 0; k < 500 && !hs; k++) begin
      hs = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!hs) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=in_ready_low required=handshake");
    end else begin
      model_accept(v, last, byp);
    end
  endtask

  task automatic send_matrix(input int base, input bit gaps, input int last_pos, input bit byp);
    logic [W-1:0] v;
    for (int e = 0; e < N * N; e++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      v = (base < 0) ? W'($urandom) : W'(base + e);
      send(v, e == last_pos, byp);
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 2000 && q.size() > 0; k++) begin
      @(posedge clk);
      #1;
    end
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0", q.size());
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    q.delete();
    idx = 0;
  endtask

  initial begin
    int target;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_last", out_last, 0);
    check("reset_busy", busy, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_out_data", out_data, 0);
    rst = 1'b0;

    // Basic: 1..9 back to back, full-rate consumer
    rand_ready = 1'b0;
    send_matrix(1, 1'b0, N * N - 1, 1'b0);
    wait_drain();
    check("basic_cycles", last_out_cyc - first_in_cyc, 2 * N * N - 1);
    check("basic_frame_err", ferr_seen, 0);

    // Backpressure and input gaps with random data
    rand_ready = 1'b1;
    for (int t = 0; t < 4; t++) send_matrix(-1, 1'b1, N * N - 1, 1'b0);
    wait_drain();

    // Framing: in_last on element 5, missing on element 9
    rand_ready = 1'b0;
    send_matrix(21, 1'b0, 4, 1'b0);
    wait_drain();
    check("framing_pulses", ferr_seen, 2);

    // Reset mid-load, then 11..19
    for (int e = 0; e < 4; e++) send(W'(100 + e), 1'b0, 1'b0);
    do_reset();
    send_matrix(11, 1'b0, N * N - 1, 1'b0);
    wait_drain();

    // Reset mid-drain after three outputs
    send_matrix(31, 1'b0, N * N - 1, 1'b0);
    target = n_out + 3;
    for (int k = 0; k < 500 && n_out < target; k++) #1;
    check("mid_drain_outputs", n_out, target);
    do_reset();
    rand_ready = 1'b1;
    send_matrix(-1, 1'b1, N * N - 1, 1'b0);
    wait_drain();

`ifdef MATRIX_TRANSPOSE_BYPASS_EN
    rand_ready = 1'b0;
    send_matrix(1, 1'b0, N * N - 1, 1'b1);
    send_matrix(1, 1'b0, N * N - 1, 1'b0);
    wait_drain();
`endif

    check("frame_err_total", ferr_seen, ferr_exp);
    check("scoreboard_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
